// File: rtl/dsi_packet_arbiter_pkg.sv
// Shared definitions for the DSI packet arbiter: FSM state encodings,
// DCS write packet types and the default LP guard length.
package dsi_packet_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ARB_IDLE        = 3'd0,
    ARB_VIDEO       = 3'd1,
    ARB_CMD_HDR     = 3'd2,
    ARB_CMD_PAYLOAD = 3'd3,
    ARB_CMD_DONE    = 3'd4
  } arb_state_e;

  // DCS write data types
  localparam logic [5:0] PTYPE_DCS_SHORT_WRITE = 6'h05;
  localparam logic [5:0] PTYPE_DCS_LONG_WRITE  = 6'h39;

  // Idle cycles of video silence before a command may be granted
  localparam int unsigned LP_GUARD_DEFAULT = 16;

  // Bytes carried per payload word (one 24-bit pixel slot)
  localparam int unsigned BYTES_PER_WORD = 3;

endpackage

// File: rtl/dsi_packet_arbiter.sv
// Arbitrates the packet-assembler request port between the video timing
// generator (always wins) and a host command source (granted only after a
// guard period of video silence, inside an LP window it forces open).
// Ports:
//   clk_i, rst_n_i          core clock, async active-low reset
//   v_*_i / v_dreq_o        video requester packet fields and data request
//   tg_force_lp_o           force-LP to the timing generator
//   cmd_*_i                 pending command fields and payload FIFO head
//   cmd_rd_o                payload FIFO pop
//   cmd_done_o, cmd_busy_o  command completion pulse / in-flight flag
//   p_*_o / p_dreq_i        packet assembler request port
module dsi_packet_arbiter
  import dsi_packet_arbiter_pkg::*;
#(
  parameter int unsigned g_pixels_per_clock = 1,
  parameter int unsigned g_lp_guard         = LP_GUARD_DEFAULT,
  localparam int unsigned g_pixel_width     = 24 * g_pixels_per_clock
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     v_req_i,
  input  logic                     v_islong_i,
  input  logic                     v_last_i,
  input  logic [5:0]               v_type_i,
  input  logic [15:0]              v_wcount_i,
  input  logic [15:0]              v_command_i,
  input  logic [g_pixel_width-1:0] v_payload_i,
  output logic                     v_dreq_o,
  output logic                     tg_force_lp_o,
  input  logic                     cmd_valid_i,
  input  logic                     cmd_islong_i,
  input  logic [5:0]               cmd_type_i,
  input  logic [15:0]              cmd_wcount_i,
  input  logic [15:0]              cmd_command_i,
  input  logic [g_pixel_width-1:0] cmd_payload_i,
  output logic                     cmd_rd_o,
  output logic                     cmd_done_o,
  output logic                     cmd_busy_o,
  output logic                     p_req_o,
  output logic                     p_islong_o,
  output logic                     p_last_o,
  output logic [5:0]               p_type_o,
  output logic [15:0]              p_wcount_o,
  output logic [15:0]              p_command_o,
  output logic [g_pixel_width-1:0] p_payload_o,
  input  logic                     p_dreq_i
);

  localparam logic [7:0]  GUARD_MAX = 8'(g_lp_guard);
  localparam logic [15:0] WORD_B    = 16'(BYTES_PER_WORD);

  arb_state_e  state_q, state_d;
  logic [7:0]  guard_q, guard_d;
  logic [15:0] rem_q, rem_d;
  logic        islong_q, islong_d;
  logic [5:0]  type_q, type_d;
  logic [15:0] wcount_q, wcount_d;
  logic [15:0] command_q, command_d;
  logic        tg_q, tg_d;
  logic        in_cmd;

  assign in_cmd = (state_q == ARB_CMD_HDR) || (state_q == ARB_CMD_PAYLOAD) ||
                  (state_q == ARB_CMD_DONE);

  // Next-state, guard counter and command field latching
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    rem_d     = rem_q;
    islong_d  = islong_q;
    type_d    = type_q;
    wcount_d  = wcount_q;
    command_d = command_q;
    tg_d      = cmd_valid_i | in_cmd;

    // Any video activity restarts the guard; CMD_DONE re-guards back-to-back commands
    if (v_req_i || (state_q == ARB_CMD_DONE)) begin
      guard_d = '0;
    end else if (guard_q != GUARD_MAX) begin
      guard_d = guard_q + 8'd1;
    end

    case (state_q)
      ARB_IDLE: begin
        if (v_req_i) begin
          state_d = ARB_VIDEO;
        end else if (cmd_valid_i && (guard_q == GUARD_MAX)) begin
          state_d   = ARB_CMD_HDR;
          islong_d  = cmd_islong_i;
          type_d    = cmd_type_i;
          wcount_d  = cmd_wcount_i;
          command_d = cmd_command_i;
          rem_d     = cmd_wcount_i;
        end
      end
      ARB_VIDEO: begin
        if (!v_req_i) state_d = ARB_IDLE;
      end
      ARB_CMD_HDR: begin
        if (p_dreq_i) begin
          if (!islong_q || (rem_q == 16'd0)) state_d = ARB_CMD_DONE;
          else                               state_d = ARB_CMD_PAYLOAD;
        end
      end
      ARB_CMD_PAYLOAD: begin
        // Last word may be partial; remaining clamps to zero instead of wrapping
        if (p_dreq_i) begin
          if (rem_q <= WORD_B) begin
            state_d = ARB_CMD_DONE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - WORD_B;
          end
        end
      end
      ARB_CMD_DONE: state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  // State and field registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ARB_IDLE;
      guard_q   <= '0;
      rem_q     <= '0;
      islong_q  <= 1'b0;
      type_q    <= '0;
      wcount_q  <= '0;
      command_q <= '0;
      tg_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      rem_q     <= rem_d;
      islong_q  <= islong_d;
      type_q    <= type_d;
      wcount_q  <= wcount_d;
      command_q <= command_d;
      tg_q      <= tg_d;
    end
  end

  // Output mux: video passes straight through, commands come from latched fields
  always_comb begin
    v_dreq_o    = 1'b0;
    cmd_rd_o    = 1'b0;
    cmd_done_o  = 1'b0;
    cmd_busy_o  = 1'b0;
    p_req_o     = 1'b0;
    p_islong_o  = 1'b0;
    p_last_o    = 1'b0;
    p_type_o    = '0;
    p_wcount_o  = '0;
    p_command_o = '0;
    p_payload_o = '0;
    case (state_q)
      ARB_VIDEO: begin
        p_req_o     = v_req_i;
        p_islong_o  = v_islong_i;
        p_last_o    = v_last_i;
        p_type_o    = v_type_i;
        p_wcount_o  = v_wcount_i;
        p_command_o = v_command_i;
        p_payload_o = v_payload_i;
        v_dreq_o    = p_dreq_i;
      end
      ARB_CMD_HDR, ARB_CMD_PAYLOAD: begin
        p_req_o     = 1'b1;
        p_islong_o  = islong_q;
        p_type_o    = type_q;
        p_wcount_o  = wcount_q;
        p_command_o = command_q;
        cmd_busy_o  = 1'b1;
        if (state_q == ARB_CMD_PAYLOAD) begin
          p_payload_o = cmd_payload_i;
          cmd_rd_o    = p_dreq_i;
        end
      end
      ARB_CMD_DONE: cmd_done_o = 1'b1;
      default: ;
    endcase
  end

  assign tg_force_lp_o = tg_q;

endmodule

// File: tb/tb_dsi_packet_arbiter.sv
module tb_dsi_packet_arbiter;
  import dsi_packet_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        v_req, v_islong, v_last;
  logic [5:0]  v_type;
  logic [15:0] v_wcount, v_command;
  logic [23:0] v_payload;
  logic        v_dreq, tg_force_lp;
  logic        cmd_valid, cmd_islong;
  logic [5:0]  cmd_type;
  logic [15:0] cmd_wcount, cmd_command;
  logic [23:0] cmd_payload;
  logic        cmd_rd, cmd_done, cmd_busy;
  logic        p_req, p_islong, p_last;
  logic [5:0]  p_type;
  logic [15:0] p_wcount, p_command;
  logic [23:0] p_payload;
  logic        p_dreq;

  int n_assert = 0;
  int n_fail   = 0;

  dsi_packet_arbiter #(.g_pixels_per_clock(1), .g_lp_guard(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .v_req_i(v_req), .v_islong_i(v_islong), .v_last_i(v_last),
    .v_type_i(v_type), .v_wcount_i(v_wcount), .v_command_i(v_command),
    .v_payload_i(v_payload), .v_dreq_o(v_dreq), .tg_force_lp_o(tg_force_lp),
    .cmd_valid_i(cmd_valid), .cmd_islong_i(cmd_islong), .cmd_type_i(cmd_type),
    .cmd_wcount_i(cmd_wcount), .cmd_command_i(cmd_command),
    .cmd_payload_i(cmd_payload), .cmd_rd_o(cmd_rd), .cmd_done_o(cmd_done),
    .cmd_busy_o(cmd_busy), .p_req_o(p_req), .p_islong_o(p_islong),
    .p_last_o(p_last), .p_type_o(p_type), .p_wcount_o(p_wcount),
    .p_command_o(p_command), .p_payload_o(p_payload), .p_dreq_i(p_dreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v_req;
    logic        v_islong;
    logic        v_last;
    logic [5:0]  v_type;
    logic [15:0] v_wcount;
    logic [23:0] v_payload;
    logic        p_dreq;
    logic        e_p_req;
    logic        e_v_dreq;
    logic        e_p_last;
    logic [5:0]  e_p_type;
    logic [15:0] e_p_wcount;
    logic [23:0] e_p_payload;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v_req = 0; v_islong = 0; v_last = 0; v_type = '0; v_wcount = '0;
    v_command = '0; v_payload = '0; p_dreq = 0;
    cmd_valid = 0; cmd_islong = 0; cmd_type = '0; cmd_wcount = '0;
    cmd_command = '0; cmd_payload = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one command with p_dreq held high; report pops and completion
  task automatic run_cmd(input logic islong, input logic [15:0] wc,
                         output int pops, output int done_seen);
    pops = 0;
    done_seen = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_islong = islong; cmd_wcount = wc;
    cmd_type = islong ? PTYPE_DCS_LONG_WRITE : PTYPE_DCS_SHORT_WRITE;
    cmd_payload = 24'hA5C3E1;
    p_dreq = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cmd_rd) pops++;
      if (cmd_done) begin
        done_seen = 1;
        cmd_valid = 0;
        p_dreq = 0;
        break;
      end
    end
  endtask

  initial begin
    int n, pops, done_seen, vbad, seen_req;

    // Reset state
    do_reset();
    rst_n = 1'b0; #1;
    chk("rst_p_req", 32'(p_req), 32'd0);
    chk("rst_tg_force_lp", 32'(tg_force_lp), 32'd0);
    chk("rst_cmd_busy", 32'(cmd_busy), 32'd0);
    chk("rst_cmd_done", 32'(cmd_done), 32'd0);
    do_reset();

    // Video pass-through vectors
    vecs[0] = '{1'b1, 1'b1, 1'b0, 6'h3E, 16'd12,  24'h112233, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 16'd0,   24'h000000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 6'h3E, 16'd12,  24'h112233, 1'b1, 1'b1, 1'b1, 1'b0, 6'h3E, 16'd12,  24'h112233};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 6'h3E, 16'd8,   24'h445566, 1'b0, 1'b1, 1'b0, 1'b0, 6'h3E, 16'd8,   24'h445566};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 6'h3E, 16'd640, 24'h778899, 1'b1, 1'b1, 1'b1, 1'b1, 6'h3E, 16'd640, 24'h778899};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 6'h00, 16'd0,   24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 16'd0,   24'h000000};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 6'h21, 16'd5,   24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 16'd0,   24'h000000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v_req = vecs[i].v_req; v_islong = vecs[i].v_islong; v_last = vecs[i].v_last;
      v_type = vecs[i].v_type; v_wcount = vecs[i].v_wcount;
      v_payload = vecs[i].v_payload; p_dreq = vecs[i].p_dreq;
      #1;
      chk($sformatf("vid%0d_p_req", i),     32'(p_req),     32'(vecs[i].e_p_req));
      chk($sformatf("vid%0d_v_dreq", i),    32'(v_dreq),    32'(vecs[i].e_v_dreq));
      chk($sformatf("vid%0d_p_last", i),    32'(p_last),    32'(vecs[i].e_p_last));
      chk($sformatf("vid%0d_p_type", i),    32'(p_type),    32'(vecs[i].e_p_type));
      chk($sformatf("vid%0d_p_wcount", i),  32'(p_wcount),  32'(vecs[i].e_p_wcount));
      chk($sformatf("vid%0d_p_payload", i), 32'(p_payload), 32'(vecs[i].e_p_payload));
      chk($sformatf("vid%0d_cmd_rd", i),    32'(cmd_rd),    32'd0);
    end

    // Short command straight after reset: guard of 16 idle cycles
    do_reset();
    cmd_valid = 1; cmd_islong = 0; cmd_type = PTYPE_DCS_SHORT_WRITE;
    cmd_command = 16'h0011;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk("short_tg_next_cycle", 32'(tg_force_lp), 32'd1);
      if (p_req) begin n = i; break; end
    end
    chk("short_grant_latency", 32'(n), 32'd17);
    chk("short_p_type", 32'(p_type), 32'h05);
    chk("short_p_command", 32'(p_command), 32'h0011);
    chk("short_busy", 32'(cmd_busy), 32'd1);
    @(negedge clk); p_dreq = 1;
    #1;
    chk("short_hdr_no_rd", 32'(cmd_rd), 32'd0);
    @(posedge clk); #1;
    chk("short_done", 32'(cmd_done), 32'd1);
    chk("short_done_p_req", 32'(p_req), 32'd0);
    chk("short_done_tg", 32'(tg_force_lp), 32'd1);
    cmd_valid = 0; p_dreq = 0;
    @(posedge clk); #1;
    chk("short_done_one_cycle", 32'(cmd_done), 32'd0);
    @(posedge clk); #1;
    chk("short_tg_drop", 32'(tg_force_lp), 32'd0);

    // Long commands: pop counts for several word counts
    run_cmd(1'b1, 16'd7, pops, done_seen);
    chk("long7_done", 32'(done_seen), 32'd1);
    chk("long7_pops", 32'(pops), 32'd3);
    run_cmd(1'b1, 16'd6, pops, done_seen);
    chk("long6_done", 32'(done_seen), 32'd1);
    chk("long6_pops", 32'(pops), 32'd2);
    run_cmd(1'b1, 16'd0, pops, done_seen);
    chk("long0_done", 32'(done_seen), 32'd1);
    chk("long0_pops", 32'(pops), 32'd0);

    // Withdrawn request before the guard expires sends nothing
    do_reset();
    cmd_valid = 1;
    repeat (5) @(posedge clk);
    @(negedge clk); cmd_valid = 0;
    seen_req = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (p_req || cmd_busy || cmd_done) seen_req = 1;
    end
    chk("withdraw_no_packet", 32'(seen_req), 32'd0);

    // Contention: video wins, command waits for 16 idle cycles after video
    repeat (20) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1; cmd_islong = 0; cmd_type = PTYPE_DCS_SHORT_WRITE;
    v_req = 1; v_wcount = 16'd12; p_dreq = 0;
    @(posedge clk); #1;
    chk("cont_video_first", 32'(p_req), 32'd1);
    chk("cont_not_busy", 32'(cmd_busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); v_req = 0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (cmd_busy) begin n = i; break; end
    end
    chk("cont_cmd_latency", 32'(n), 32'd17);
    @(negedge clk); p_dreq = 1;
    @(posedge clk); #1;
    chk("cont_done", 32'(cmd_done), 32'd1);
    cmd_valid = 0; p_dreq = 0;

    // Video arrives during a long command with toggling p_dreq
    repeat (20) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1; cmd_islong = 1; cmd_wcount = 16'd12;
    cmd_type = PTYPE_DCS_LONG_WRITE; v_wcount = 16'd640;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cmd_busy) begin n = 1; break; end
    end
    chk("mid_granted", 32'(n), 32'd1);
    vbad = 0; done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      p_dreq = ~p_dreq;
      if (i == 2) v_req = 1;
      #1;
      if (v_dreq) vbad = 1;
      @(posedge clk); #1;
      if (v_dreq) vbad = 1;
      if (cmd_done) begin done_seen = 1; break; end
    end
    chk("mid_done", 32'(done_seen), 32'd1);
    chk("mid_v_dreq_held", 32'(vbad), 32'd0);
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("mid_idle_p_req", 32'(p_req), 32'd0);
    @(posedge clk); #1;
    chk("mid_video_p_req", 32'(p_req), 32'd1);
    chk("mid_video_wcount", 32'(p_wcount), 32'd640);
    chk("mid_video_dreq", 32'(v_dreq), 32'(p_dreq));
    @(negedge clk); v_req = 0; p_dreq = 0;

    // Async reset in CMD_PAYLOAD with 9 bytes remaining
    repeat (20) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1; cmd_islong = 1; cmd_wcount = 16'd15; p_dreq = 1;
    cmd_payload = 24'h5A5A5A;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cmd_busy) begin n = 1; break; end
    end
    chk("rstmid_granted", 32'(n), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_payload", 32'(p_payload), 32'h5A5A5A);
    chk("rstmid_rd", 32'(cmd_rd), 32'd1);
    rst_n = 0; #1;
    chk("rstmid_p_req", 32'(p_req), 32'd0);
    chk("rstmid_rd_off", 32'(cmd_rd), 32'd0);
    chk("rstmid_busy", 32'(cmd_busy), 32'd0);
    chk("rstmid_tg", 32'(tg_force_lp), 32'd0);
    chk("rstmid_payload_off", 32'(p_payload), 32'd0);
    cmd_valid = 0; p_dreq = 0;
    @(negedge clk); rst_n = 1;
    seen_req = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (cmd_done || p_req || cmd_busy) seen_req = 1;
    end
    chk("rstmid_no_done", 32'(seen_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_packet_arbiter.md
Name: dsi_packet_arbiter

Overview:
- Shares the single packet-assembler request port between two requesters: the video timing generator and a host command (DCS/generic) source.
- Video traffic always has priority.
- Command packets are issued only in LP windows. The arbiter opens those windows by driving the timing generator's force-LP input.
- Sits between the timing generator and the packet assembler, inside the DSI core.

Parameters:
- g_pixels_per_clock, 1, payload word width = 24*g_pixels_per_clock (g_pixel_width)
- g_lp_guard, 16, idle cycles of v_req_i low required before a command is granted (8-bit counter, saturating)

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  reset; asynchronous, active-low
- v_req_i, v_islong_i, v_last_i  in  1 each  video requester packet fields
- v_type_i  in  6  video packet type
- v_wcount_i, v_command_i  in  16 each  video word count / command
- v_payload_i  in  g_pixel_width  video payload
- v_dreq_o  out  1  data request returned to video requester
- tg_force_lp_o  out  1  drives timing generator force-LP input
- cmd_valid_i  in  1  command pending (held until cmd_done_o)
- cmd_islong_i  in  1  long/short
- cmd_type_i  in  6  data type
- cmd_wcount_i  in  16  long: payload bytes; short: ignored
- cmd_command_i  in  16  short-packet parameter bytes
- cmd_payload_i  in  g_pixel_width  command payload word (FIFO head)
- cmd_rd_o  out  1  pop command payload FIFO
- cmd_done_o  out  1  one-cycle pulse on command completion
- cmd_busy_o  out  1  command granted and in flight
- p_req_o, p_islong_o, p_last_o  out  1 each  to packet assembler
- p_type_o  out  6
- p_wcount_o, p_command_o  out  16 each
- p_payload_o  out  g_pixel_width
- p_dreq_i  in  1  assembler data request

Behaviour:
- Reset, async, rst_n_i low:
  - State is IDLE; guard_cnt=0; remaining=0.
  - All outputs are 0, except tg_force_lp_o, which is 0 until a command is pending.
- States: IDLE, VIDEO, CMD_HDR, CMD_PAYLOAD, CMD_DONE.
- guard_cnt:
  - Clears to 0 while v_req_i=1.
  - Otherwise increments, saturating at g_lp_guard.
- tg_force_lp_o is registered and equals (cmd_valid_i | state in CMD_*).
  - It asserts one cycle after cmd_valid_i rises.
  - It drops the cycle after CMD_DONE, unless cmd_valid_i is still high.
- IDLE:
  - v_req_i=1 -> VIDEO. This has priority even if cmd_valid_i is also high.
  - Else cmd_valid_i=1 and guard_cnt==g_lp_guard -> CMD_HDR. On entry, latch cmd_* fields and set remaining=cmd_wcount_i.
- VIDEO:
  - p_* outputs are combinationally equal to v_*_i.
  - v_dreq_o=p_dreq_i.
  - Leave to IDLE when v_req_i=0.
- CMD_HDR:
  - p_req_o=1 and p_type/p_islong/p_wcount/p_command come from the latched fields; p_last_o=0.
  - On p_dreq_i=1: if short, or long with remaining==0 -> CMD_DONE. Else -> CMD_PAYLOAD.
- CMD_PAYLOAD:
  - p_payload_o=cmd_payload_i.
  - cmd_rd_o=p_dreq_i (combinational).
  - On each p_dreq_i: if remaining<=3 -> CMD_DONE with remaining=0; else remaining-=3. Subtraction is 16-bit and never wraps.
  - p_dreq_i low stalls; there is no timeout.
- CMD_DONE:
  - p_req_o=0 and cmd_done_o=1 for exactly one cycle.
  - guard_cnt is forced to 0 (re-guard between back-to-back commands).
  - Next state IDLE.
- cmd_busy_o=1 in CMD_HDR and CMD_PAYLOAD.
- Outside VIDEO: v_dreq_o=0.
  - A video request arriving during CMD_* is stalled; its packet is held upstream and nothing is lost.
  - It is granted in IDLE on the next cycle after CMD_DONE.
- Outside CMD_PAYLOAD, p_payload_o is 0 unless in VIDEO.
- cmd_valid_i falling before grant withdraws the request; no packet is sent.
- cmd_valid_i falling after grant is ignored; the command completes.
- Reset mid-packet aborts immediately. The upstream FIFO flush is the host's responsibility.

Decomposition:
- dsi_defs.vh gains:
  - arbiter state encodings (ARB_IDLE..ARB_CMD_DONE);
  - a PTYPE_DCS_SHORT_WRITE/PTYPE_DCS_LONG_WRITE pair;
  - the default guard length.
- No sub-module. The output mux and the FSM are one file; the guard counter is inline.

Test Plan:
- Video only: timing generator drives v_req_i high for 3 packets (wcount 12, 8, 640) -> p_* mirrors v_* cycle-for-cycle, v_dreq_o==p_dreq_i, no cmd_rd_o.
- Short command in LP, g_lp_guard=16: v_req_i low, cmd_valid_i type 0x05, command 0x0011 -> tg_force_lp_o=1 next cycle; p_req_o rises 16 cycles later; on p_dreq_i -> cmd_done_o pulse, 0 cmd_rd_o.
- Long command wcount=7: -> 3 cmd_rd_o pulses (remaining 7, 4, 1), then CMD_DONE. wcount=6 -> 2 pops. wcount=0 long -> 0 pops.
- Contention: cmd_valid_i and v_req_i rise in the same IDLE cycle -> VIDEO granted. Command is granted only after v_req_i low for 16 cycles.
- Video arrives mid-command (v_req_i rises in CMD_PAYLOAD, p_dreq_i toggling) -> v_dreq_o stays 0; VIDEO entered 2 cycles after the cmd_done_o pulse.
- Async reset asserted in CMD_PAYLOAD with remaining=9 -> all outputs 0 immediately. After release, state is IDLE and no cmd_done_o.
